// File: rtl/ysyx_22050854_rf_wb_arbiter.sv
// Writeback arbiter for the single register-file write port: ALU/multi-cycle
// arbitration with a starvation guard, a registered write stage and a busy scoreboard.
module ysyx_22050854_rf_wb_arbiter #(
  parameter int XLEN       = 64,
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 2
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_rd,
  input  logic [XLEN-1:0] b_data,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd_chk,
  output logic            hazard,
  output logic            rf_wen,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [NREG-1:0] busy_vec
);

  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            rf_wen_q, rf_wen_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0] busy_q, busy_d;

  logic a_starved;
  logic a_grant;
  logic b_grant;
  logic iss_take;

  // A source is hazardous while its value is still outstanding or sitting in the write stage.
  function automatic logic src_hazard(input logic [AW-1:0]   r,
                                      input logic [NREG-1:0] busy,
                                      input logic            wen,
                                      input logic [AW-1:0]   waddr);
    return (r != '0) && (busy[r] || (wen && (waddr == r)));
  endfunction

  // B normally wins; A is forced through once it has been denied STARVE_MAX times in a row.
  always_comb begin
    a_starved = (starve_cnt_q == STARVE_TOP);
    a_grant   = a_valid && (!b_valid || a_starved);
    b_grant   = b_valid && !a_grant;
    iss_ready = !busy_q[iss_rd] || (iss_rd == '0);
    iss_take  = iss_valid && iss_ready && (iss_rd != '0);
  end

  assign a_ready = a_grant;
  assign b_ready = b_grant;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    starve_cnt_d = '0;
    if (a_valid && !a_grant) begin
      starve_cnt_d = a_starved ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  // Writes to x0 are accepted upstream but never reach the register file.
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (a_grant && (a_rd != '0)) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = a_rd;
      rf_wdata_d = a_data;
    end else if (b_grant && (b_rd != '0)) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = b_rd;
      rf_wdata_d = b_data;
    end
  end

  // Ordering encodes priority: a same-cycle issue beats the completion, flush beats both.
  always_comb begin
    busy_d = busy_q;
    if (b_grant) begin
      busy_d[b_rd] = 1'b0;
    end
    if (iss_take) begin
      busy_d[iss_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    hazard = src_hazard(rs1,    busy_q, rf_wen_q, rf_waddr_q)
           | src_hazard(rs2,    busy_q, rf_wen_q, rf_waddr_q)
           | src_hazard(rd_chk, busy_q, rf_wen_q, rf_waddr_q);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      busy_q       <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_ysyx_22050854_rf_wb_arbiter.sv
// Directed bench for the writeback arbiter: a behavioural model checked every cycle,
// plus literal expectations for the reset, contention, scoreboard, corner and flush cases.
module tb_ysyx_22050854_rf_wb_arbiter;
  localparam int XLEN       = 64;
  localparam int NREG       = 32;
  localparam int AW         = 5;
  localparam int STARVE_MAX = 2;

  logic            clock = 1'b0;
  logic            rst_n;
  logic            a_valid, b_valid, iss_valid, flush;
  logic            a_ready, b_ready, iss_ready, hazard, rf_wen;
  logic [AW-1:0]   a_rd, b_rd, iss_rd, rs1, rs2, rd_chk, rf_waddr;
  logic [XLEN-1:0] a_data, b_data, rf_wdata;
  logic [NREG-1:0] busy_vec;

  ysyx_22050854_rf_wb_arbiter #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock(clock), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
    .flush(flush), .rs1(rs1), .rs2(rs2), .rd_chk(rd_chk), .hazard(hazard),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
  );

  initial forever #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a set of outstanding registers, a denial count and the pending write.
  bit              m_busy [NREG];
  int              m_starve = 0;
  bit              m_wen    = 1'b0;
  bit [AW-1:0]     m_waddr  = '0;
  bit [XLEN-1:0]   m_wdata  = '0;
  bit              chk_en   = 1'b0;

  function automatic bit model_src_hz(input int r);
    return (r != 0) && (m_busy[r] || (m_wen && (int'(m_waddr) == r)));
  endfunction

  always @(negedge clock or negedge rst_n) begin : model_cmp
    bit          ag, bg, iss_ok, hz;
    bit [NREG-1:0] bv;
    bit          nb [NREG];
    if (!rst_n) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_starve = 0;
      m_wen    = 1'b0;
      m_waddr  = '0;
      m_wdata  = '0;
    end
    if (!clock && chk_en) begin
      if (a_valid && b_valid) begin
        ag = (m_starve >= STARVE_MAX);
        bg = !ag;
      end else begin
        ag = a_valid;
        bg = b_valid;
      end
      iss_ok = (iss_rd == 0) || !m_busy[iss_rd];
      hz = model_src_hz(int'(rs1)) || model_src_hz(int'(rs2)) || model_src_hz(int'(rd_chk));
      for (int i = 0; i < NREG; i++) bv[i] = m_busy[i];
      check("m_a_ready",   a_ready,   ag);
      check("m_b_ready",   b_ready,   bg);
      check("m_iss_ready", iss_ready, iss_ok);
      check("m_hazard",    hazard,    hz);
      check("m_rf_wen",    rf_wen,    m_wen);
      check("m_rf_waddr",  rf_waddr,  m_waddr);
      check("m_rf_wdata",  rf_wdata,  m_wdata);
      check("m_busy_vec",  busy_vec,  bv);
      if (rst_n) begin
        if (ag || !a_valid) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
        if (ag && a_rd != 0) begin
          m_wen = 1'b1; m_waddr = a_rd; m_wdata = a_data;
        end else if (bg && b_rd != 0) begin
          m_wen = 1'b1; m_waddr = b_rd; m_wdata = b_data;
        end else begin
          m_wen = 1'b0;
        end
        nb = m_busy;
        if (bg) nb[b_rd] = 1'b0;
        if (iss_valid && iss_ok && iss_rd != 0) nb[iss_rd] = 1'b1;
        if (flush) foreach (nb[i]) nb[i] = 1'b0;
        m_busy = nb;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; iss_valid = 1'b0; flush = 1'b0;
    a_rd = '0; b_rd = '0; iss_rd = '0; rs1 = '0; rs2 = '0; rd_chk = '0;
    a_data = '0; b_data = '0;
    #1 chk_en = 1'b1;

    // Reset state: with both requesting and no denials yet, B is the one granted.
    @(negedge clock);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 1);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_busy", busy_vec, 0);
    tick();
    a_valid = 1'b0; b_valid = 1'b0; rst_n = 1'b1;
    @(negedge clock);
    check("idle_rf_wen", rf_wen, 0);
    tick();

    // A alone
    a_valid = 1'b1; a_rd = 5; a_data = 64'hDEAD;
    @(negedge clock);
    check("t2_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0; rs1 = 5;
    @(negedge clock);
    check("t2_rf_wen", rf_wen, 1);
    check("t2_rf_waddr", rf_waddr, 5);
    check("t2_rf_wdata", rf_wdata, 64'hDEAD);
    check("t2_hazard", hazard, 1);
    tick();
    rs1 = 0;
    @(negedge clock);
    check("t2_wen_drop", rf_wen, 0);
    check("t2_waddr_hold", rf_waddr, 5);
    check("t2_hazard_clr", hazard, 0);
    tick();

    // Contention: grants B, B, A, B
    a_valid = 1'b1; a_rd = 1; a_data = 64'h11;
    b_valid = 1'b1; b_rd = 2; b_data = 64'h22;
    @(negedge clock);
    check("t3_c1_b", b_ready, 1);
    check("t3_c1_a", a_ready, 0);
    tick();
    @(negedge clock);
    check("t3_c2_b", b_ready, 1);
    check("t3_c2_a", a_ready, 0);
    check("t3_c2_waddr", rf_waddr, 2);
    check("t3_c2_wdata", rf_wdata, 64'h22);
    tick();
    @(negedge clock);
    check("t3_c3_a", a_ready, 1);
    check("t3_c3_b", b_ready, 0);
    tick();
    a_rd = 3; a_data = 64'h33;
    @(negedge clock);
    check("t3_c4_b", b_ready, 1);
    check("t3_c4_a", a_ready, 0);
    check("t3_c4_waddr", rf_waddr, 1);
    check("t3_c4_wdata", rf_wdata, 64'h11);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clock);
    check("t3_last_waddr", rf_waddr, 2);
    tick();

    // Scoreboard
    iss_valid = 1'b1; iss_rd = 7;
    @(negedge clock);
    check("t4_iss_ready", iss_ready, 1);
    tick();
    iss_valid = 1'b0; rs2 = 7;
    @(negedge clock);
    check("t4_busy7", busy_vec, 32'h80);
    check("t4_hazard_busy", hazard, 1);
    check("t4_iss_blocked", iss_ready, 0);
    tick();
    b_valid = 1'b1; b_rd = 7; b_data = 64'h77;
    @(negedge clock);
    check("t4_b_ready", b_ready, 1);
    check("t4_hazard_b", hazard, 1);
    tick();
    b_valid = 1'b0;
    @(negedge clock);
    check("t4_busy_clr", busy_vec, 0);
    check("t4_hazard_wstage", hazard, 1);
    check("t4_waddr", rf_waddr, 7);
    tick();
    @(negedge clock);
    check("t4_hazard_done", hazard, 0);
    tick();
    rs2 = 0;

    // Corner: same-cycle set and clear of x9
    iss_valid = 1'b1; iss_rd = 9; b_valid = 1'b1; b_rd = 9; b_data = 64'h99;
    @(negedge clock);
    check("t5_b_ready", b_ready, 1);
    check("t5_iss_ready", iss_ready, 1);
    tick();
    iss_valid = 1'b0; b_valid = 1'b0;
    @(negedge clock);
    check("t5_set_wins", busy_vec, 32'h200);
    tick();
    b_valid = 1'b1; b_rd = 9; b_data = 64'h999;
    @(negedge clock);
    tick();
    b_valid = 1'b0;
    @(negedge clock);
    check("t5_busy9_clr", busy_vec, 0);
    check("t5_waddr9", rf_waddr, 9);
    check("t5_wdata9", rf_wdata, 64'h999);
    tick();
    // Corner: A grant to x0
    a_valid = 1'b1; a_rd = 0; a_data = 64'h5A;
    @(negedge clock);
    check("t5_a0_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    @(negedge clock);
    check("t5_a0_wen", rf_wen, 0);
    check("t5_a0_waddr", rf_waddr, 9);
    tick();
    // Corner: issue to x0
    iss_valid = 1'b1; iss_rd = 0;
    @(negedge clock);
    check("t5_iss0_ready", iss_ready, 1);
    tick();
    iss_valid = 1'b0;
    @(negedge clock);
    check("t5_iss0_busy", busy_vec, 0);
    tick();

    // Flush with x7 and x10 outstanding, plus a same-cycle issue that must lose
    iss_valid = 1'b1; iss_rd = 7;
    tick();
    iss_rd = 10;
    tick();
    iss_valid = 1'b0;
    @(negedge clock);
    check("t6_busy_pre", busy_vec, 32'h480);
    tick();
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 11;
    @(negedge clock);
    tick();
    flush = 1'b0; iss_valid = 1'b0; rd_chk = 10;
    @(negedge clock);
    check("t6_busy_flushed", busy_vec, 0);
    check("t6_hazard_none", hazard, 0);
    tick();
    b_valid = 1'b1; b_rd = 10; b_data = 64'hAA;
    @(negedge clock);
    check("t6_b_ready", b_ready, 1);
    tick();
    b_valid = 1'b0;
    @(negedge clock);
    check("t6_wen", rf_wen, 1);
    check("t6_waddr", rf_waddr, 10);
    check("t6_wdata", rf_wdata, 64'hAA);
    check("t6_hazard_wstage", hazard, 1);
    tick();
    rd_chk = 0;

    // Asynchronous reset mid-cycle while a write is in the write stage
    iss_valid = 1'b1; iss_rd = 12; a_valid = 1'b1; a_rd = 13; a_data = 64'h1313;
    tick();
    iss_valid = 1'b0; a_valid = 1'b0;
    #1;
    check("t1_pre_wen", rf_wen, 1);
    check("t1_pre_busy", busy_vec, 32'h1000);
    #1 rst_n = 1'b0;
    #1;
    check("t1_async_wen", rf_wen, 0);
    check("t1_async_busy", busy_vec, 0);
    check("t1_async_waddr", rf_waddr, 0);
    check("t1_async_wdata", rf_wdata, 0);
    @(negedge clock);
    tick();
    rst_n = 1'b1;
    @(negedge clock);
    check("t1_after_wen", rf_wen, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
